// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, per-button debounce FSM with
// auto-repeat, registered level/event outputs and a wrapping press counter.
module btn_debounce #(
    parameter int unsigned NBTN     = 2,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned HOLD     = 10,
    parameter int unsigned REPEAT   = 3
) (
    input  logic            clk_out,
    input  logic            rst,
    input  logic [NBTN-1:0] prbtn_raw,
    output logic [NBTN-1:0] btn_level,
    output logic [NBTN-1:0] btn_press,
    output logic [NBTN-1:0] btn_release,
    output logic [NBTN-1:0] btn_repeat,
    output logic [7:0]      press_cnt
);

    localparam int unsigned CW = $clog2(DEBOUNCE);
    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [CW-1:0] CMax = CW'(DEBOUNCE - 1);
    localparam logic [HW-1:0] HMax = HW'(HOLD - 1);
    // Reload so the next repeat lands REPEAT cycles later.
    localparam logic [HW-1:0] HRld = HW'(HOLD - REPEAT);

    typedef enum logic [1:0] {
        StRel,
        StPwait,
        StPrs,
        StRwait
    } state_e;

    logic [NBTN-1:0] sync1_q, sync2_q;
    logic [NBTN-1:0] press_vec;
    logic [7:0]      press_cnt_q, press_cnt_d;

    // Two-flop synchronizer; released (1) out of reset.
    always_ff @(posedge clk_out or negedge rst) begin
        if (!rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= prbtn_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < NBTN; g++) begin : g_btn
        state_e        state_q, state_d;
        logic [CW-1:0] c_q, c_d;
        logic [HW-1:0] h_q, h_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic          repeat_q, repeat_d;
        logic          s;

        assign s = sync2_q[g];

        // Next-state, counters and event decode for one button.
        always_comb begin
            state_d   = state_q;
            c_d       = c_q;
            h_d       = h_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            repeat_d  = 1'b0;
            unique case (state_q)
                StRel: begin
                    if (!s) begin
                        state_d = StPwait;
                        c_d     = '0;
                    end
                end
                StPwait: begin
                    if (s) begin
                        state_d = StRel;
                    end else if (c_q == CMax) begin
                        state_d = StPrs;
                        press_d = 1'b1;
                        h_d     = '0;
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end
                StPrs: begin
                    if (s) begin
                        // Hold counter is frozen while the release is qualified.
                        state_d = StRwait;
                        c_d     = '0;
                    end else if (h_q == HMax) begin
                        repeat_d = 1'b1;
                        h_d      = HRld;
                    end else begin
                        h_d = h_q + HW'(1);
                    end
                end
                StRwait: begin
                    if (!s) begin
                        state_d = StPrs;
                    end else if (c_q == CMax) begin
                        state_d   = StRel;
                        release_d = 1'b1;
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end
                default: state_d = StRel;
            endcase
            level_d = !((state_d == StPrs) || (state_d == StRwait));
        end

        // Per-button state and registered outputs.
        always_ff @(posedge clk_out or negedge rst) begin
            if (!rst) begin
                state_q   <= StRel;
                c_q       <= '0;
                h_q       <= '0;
                level_q   <= 1'b1;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                state_q   <= state_d;
                c_q       <= c_d;
                h_q       <= h_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                repeat_q  <= repeat_d;
            end
        end

        assign press_vec[g]   = press_d;
        assign btn_level[g]   = level_q;
        assign btn_press[g]   = press_q;
        assign btn_release[g] = release_q;
        assign btn_repeat[g]  = repeat_q;
    end

    // Add the number of presses accepted on this edge; wraps modulo 256.
    always_comb begin
        press_cnt_d = press_cnt_q;
        for (int i = 0; i < NBTN; i++) begin
            press_cnt_d = press_cnt_d + 8'(press_vec[i]);
        end
    end

    // Press counter register, updated on the same edge as btn_press.
    always_ff @(posedge clk_out or negedge rst) begin
        if (!rst) begin
            press_cnt_q <= '0;
        end else begin
            press_cnt_q <= press_cnt_d;
        end
    end

    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: run-length behavioural model compared
// every cycle, plus directed scenarios with hand-computed latencies.
module tb_btn_debounce;

    localparam int NBTN     = 2;
    localparam int DEBOUNCE = 4;
    localparam int HOLD     = 10;
    localparam int REPEAT   = 3;

    logic            clk_out = 1'b0;
    logic            rst     = 1'b0;
    logic [NBTN-1:0] prbtn_raw = '1;
    logic [NBTN-1:0] btn_level, btn_press, btn_release, btn_repeat;
    logic [7:0]      press_cnt;

    int checks = 0;
    int errors = 0;

    btn_debounce #(
        .NBTN    (NBTN),
        .DEBOUNCE(DEBOUNCE),
        .HOLD    (HOLD),
        .REPEAT  (REPEAT)
    ) dut (
        .clk_out    (clk_out),
        .rst        (rst),
        .prbtn_raw  (prbtn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat),
        .press_cnt  (press_cnt)
    );

    always #5 clk_out = ~clk_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: a level flips after DEBOUNCE+1 consecutive synchronized
    // samples disagreeing with it; repeats fire when the held-sample count hits
    // HOLD, HOLD+REPEAT, HOLD+2*REPEAT, ...
    bit m_s1  [NBTN] = '{default: 1'b1};
    bit m_s2  [NBTN] = '{default: 1'b1};
    bit m_lvl [NBTN] = '{default: 1'b1};
    int m_run [NBTN] = '{default: 0};
    int m_held[NBTN] = '{default: 0};
    logic [NBTN-1:0] m_press = '0, m_rel = '0, m_rep = '0;
    int m_cnt = 0;

    always @(posedge clk_out or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NBTN; i++) begin
                m_s1[i] = 1'b1; m_s2[i] = 1'b1; m_lvl[i] = 1'b1;
                m_run[i] = 0; m_held[i] = 0;
            end
            m_press = '0; m_rel = '0; m_rep = '0; m_cnt = 0;
        end else begin
            m_press = '0; m_rel = '0; m_rep = '0;
            for (int i = 0; i < NBTN; i++) begin
                bit s;
                s = m_s2[i];
                if (s != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEBOUNCE + 1) begin
                        m_lvl[i] = s;
                        m_run[i] = 0;
                        if (!s) begin
                            m_press[i] = 1'b1;
                            m_held[i]  = 0;
                            m_cnt      = (m_cnt + 1) % 256;
                        end else begin
                            m_rel[i] = 1'b1;
                        end
                    end
                end else begin
                    // A held sample only counts when no release is being qualified.
                    if (!m_lvl[i] && m_run[i] == 0) begin
                        m_held[i]++;
                        if (m_held[i] >= HOLD && (m_held[i] - HOLD) % REPEAT == 0)
                            m_rep[i] = 1'b1;
                    end
                    m_run[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = prbtn_raw[i];
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_out) begin
        logic [NBTN-1:0] lv;
        for (int i = 0; i < NBTN; i++) lv[i] = m_lvl[i];
        chk("level",   32'(btn_level),   32'(lv));
        chk("press",   32'(btn_press),   32'(m_press));
        chk("release", 32'(btn_release), 32'(m_rel));
        chk("repeat",  32'(btn_repeat),  32'(m_rep));
        chk("cnt",     32'(press_cnt),   32'(m_cnt));
    end

    // Edges from the next posedge until the chosen event is seen (99 on timeout).
    task automatic count_to(input int b, input bit rel, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk_out);
            n++;
            @(negedge clk_out);
            if (rel ? btn_release[b] : btn_press[b]) seen = 1'b1;
        end
        if (!seen) n = 99;
    endtask

    task automatic idle(input int n);
        prbtn_raw = '1;
        repeat (n) @(negedge clk_out);
    endtask

    task automatic press_once();
        prbtn_raw[0] = 1'b0;
        repeat (9) @(negedge clk_out);
        prbtn_raw[0] = 1'b1;
        repeat (9) @(negedge clk_out);
    endtask

    initial begin
        int n, rep_n, first, last, base, need;
        int dur[NBTN];

        repeat (3) @(negedge clk_out);
        rst = 1'b1;
        idle(4);

        // Clean press and hold on button 0.
        base = m_cnt;
        prbtn_raw[0] = 1'b0;
        count_to(0, 1'b0, n);
        chk("press_latency", 32'(n), 32'd7);
        chk("cnt_after_press", 32'(press_cnt), 32'((base + 1) % 256));
        chk("level_pressed", 32'(btn_level), 32'b10);
        rep_n = 0; first = 0; last = 0;
        for (int e = 8; e <= 30; e++) begin
            @(posedge clk_out);
            @(negedge clk_out);
            if (btn_repeat[0]) begin
                rep_n++;
                if (first == 0) first = e;
                last = e;
            end
        end
        chk("repeat_count", 32'(rep_n), 32'd5);
        chk("repeat_first", 32'(first), 32'd17);
        chk("repeat_last",  32'(last),  32'd29);

        // Release bounce: high 2, low 1, then steady high.
        prbtn_raw[0] = 1'b1;
        repeat (2) @(negedge clk_out);
        prbtn_raw[0] = 1'b0;
        @(negedge clk_out);
        prbtn_raw[0] = 1'b1;
        count_to(0, 1'b1, n);
        chk("release_latency", 32'(n), 32'd7);
        idle(4);

        // Glitch on button 1: 3 edges low.
        base = m_cnt;
        prbtn_raw[1] = 1'b0;
        repeat (3) @(negedge clk_out);
        prbtn_raw[1] = 1'b1;
        rep_n = 0;
        for (int e = 0; e < 12; e++) begin
            @(negedge clk_out);
            if (btn_press[1] || btn_release[1] || !btn_level[1]) rep_n++;
        end
        chk("glitch_events", 32'(rep_n), 32'd0);
        chk("glitch_cnt", 32'(press_cnt), 32'(base));

        // Simultaneous press.
        base = m_cnt;
        prbtn_raw = 2'b00;
        count_to(0, 1'b0, n);
        chk("sim_latency", 32'(n), 32'd7);
        chk("sim_press", 32'(btn_press), 32'b11);
        chk("sim_level", 32'(btn_level), 32'b00);
        chk("sim_cnt", 32'(press_cnt), 32'((base + 2) % 256));
        idle(14);

        // Asynchronous reset mid-stream.
        #2 rst = 1'b0;
        #1;
        chk("rst_level", 32'(btn_level), 32'b11);
        chk("rst_pulses", 32'({btn_press, btn_release, btn_repeat}), 32'd0);
        chk("rst_cnt", 32'(press_cnt), 32'd0);
        @(negedge clk_out);
        rst = 1'b1;
        idle(10);
        chk("post_rst_level", 32'(btn_level), 32'b11);
        chk("post_rst_cnt", 32'(press_cnt), 32'd0);

        // Wrap: reach 255, then one more press gives 0.
        need = (255 - m_cnt + 256) % 256;
        for (int k = 0; k < need; k++) press_once();
        chk("cnt_255", 32'(press_cnt), 32'd255);
        press_once();
        chk("cnt_wrap", 32'(press_cnt), 32'd0);

        // Reset while button 1 is in the debounce window; re-press takes full time.
        prbtn_raw[1] = 1'b0;
        repeat (4) @(negedge clk_out);
        #2 rst = 1'b0;
        #1;
        chk("pwait_rst_press", 32'(btn_press), 32'd0);
        chk("pwait_rst_level", 32'(btn_level), 32'b11);
        @(negedge clk_out);
        rst = 1'b1;
        count_to(1, 1'b0, n);
        chk("repress_latency", 32'(n), 32'd7);
        idle(14);

        // Randomized bouncing with occasional long holds and one reset pulse.
        dur = '{default: 0};
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < NBTN; i++) begin
                if (dur[i] == 0) begin
                    prbtn_raw[i] = 1'($urandom_range(0, 1));
                    dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 30)
                                                         : $urandom_range(1, 5);
                end
                dur[i]--;
            end
            if (cyc == 2000) begin
                #2 rst = 1'b0;
                #1;
                chk("rand_rst_cnt", 32'(press_cnt), 32'd0);
                @(negedge clk_out);
                rst = 1'b1;
            end
            @(negedge clk_out);
        end
        idle(14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
